w_wb_arbiter: RTL and testbench

//  Owns the single GRF write port (A3/WD/PC). Merges in-order pipeline W-stage writebacks with out-of-band results from the multi-cycle MDU.
//  MDU results are buffered in a small FIFO and drained in idle W slots.

---
 rtl/w_wb_arbiter.sv | 163 ++++++++++++++++
 tb/tb_w_wb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/w_wb_arbiter.sv
// w_wb_arbiter: owns the single GRF write port, merging in-order W-stage
// writebacks with MDU results buffered in a small FIFO and drained in idle
// W slots. Also provides pending-destination lookup and a starvation stall.
module w_wb_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    // W-stage writeback
    input  logic                   p_we,
    input  logic [4:0]             p_a3,
    input  logic [31:0]            p_wd,
    input  logic [31:0]            p_pc,
    // MDU result stream
    input  logic                   m_valid,
    output logic                   m_ready,
    input  logic [4:0]             m_a3,
    input  logic [31:0]            m_wd,
    input  logic [31:0]            m_pc,
    // GRF write port
    output logic [4:0]             grf_a3,
    output logic [31:0]            grf_wd,
    output logic [31:0]            grf_pc,
    // Hazard unit interface
    input  logic [4:0]             q_a1,
    input  logic [4:0]             q_a2,
    output logic                   q_hit1,
    output logic                   q_hit2,
    output logic                   stall_req,
    output logic [$clog2(DEPTH):0] fifo_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } mdu_entry_t;

    mdu_entry_t     mem_q [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]  starve_q, starve_d;

    logic           empty;
    logic           full;
    logic           p_sel;
    logic           enq;
    logic           deq;
    mdu_entry_t     head;
    logic [PW-1:0]  offs [DEPTH];
    logic [DEPTH-1:0] entry_valid;

    // Occupancy flags and handshake/dequeue decisions from registered state
    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == CW'(DEPTH));
        p_sel   = p_we && (p_a3 != 5'd0);
        m_ready = !reset && !full;
        enq     = m_valid && m_ready && (m_a3 != 5'd0);
        deq     = !reset && !empty && !p_sel;
        head    = mem_q[rd_ptr_q];
    end

    // Write-port select: pipeline has priority, FIFO head fills idle slots
    always_comb begin
        grf_a3 = 5'd0;
        grf_wd = 32'd0;
        grf_pc = 32'd0;
        if (!reset) begin
            if (p_sel) begin
                grf_a3 = p_a3;
                grf_wd = p_wd;
                grf_pc = p_pc;
            end else if (!empty) begin
                grf_a3 = head.a3;
                grf_wd = head.wd;
                grf_pc = head.pc;
            end
        end
    end

    // Slot i is live when its distance from the head is below the occupancy
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            offs[i]        = PW'(i) - rd_ptr_q;
            entry_valid[i] = ({1'b0, offs[i]} < cnt_q);
        end
    end

    // Pending-destination lookup over all live entries, register 0 excluded
    always_comb begin
        q_hit1 = 1'b0;
        q_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (mem_q[i].a3 == q_a1) && (q_a1 != 5'd0)) begin
                q_hit1 = 1'b1;
            end
            if (entry_valid[i] && (mem_q[i].a3 == q_a2) && (q_a2 != 5'd0)) begin
                q_hit2 = 1'b1;
            end
        end
    end

    // Next pointer and occupancy values
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (enq && !deq) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!enq && deq) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Starvation counter: counts blocked cycles, saturating at the limit
    always_comb begin
        starve_d = starve_q;
        if (empty || deq) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    // Entry storage; contents are qualified by occupancy so no reset needed
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= '{a3: m_a3, wd: m_wd, pc: m_pc};
        end
    end

    assign stall_req = (starve_q == SW'(STARVE_LIMIT));
    assign fifo_cnt  = cnt_q;

endmodule

// File: tb/tb_w_wb_arbiter.sv
// tb_w_wb_arbiter: directed vector table plus multi-cycle sequences.
module tb_w_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_we;
    logic [4:0]  p_a3;
    logic [31:0] p_wd, p_pc;
    logic        m_valid, m_ready;
    logic [4:0]  m_a3;
    logic [31:0] m_wd, m_pc;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pc;
    logic [4:0]  q_a1, q_a2;
    logic        q_hit1, q_hit2, stall_req;
    logic [2:0]  fifo_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    w_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .p_we(p_we), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc),
        .m_valid(m_valid), .m_ready(m_ready), .m_a3(m_a3), .m_wd(m_wd), .m_pc(m_pc),
        .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .q_a1(q_a1), .q_a2(q_a2), .q_hit1(q_hit1), .q_hit2(q_hit2),
        .stall_req(stall_req), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        p_we;
        logic [4:0]  p_a3;
        logic [31:0] p_wd;
        logic [31:0] p_pc;
        logic        m_valid;
        logic [4:0]  m_a3;
        logic [31:0] m_wd;
        logic [31:0] m_pc;
        logic [4:0]  q_a1;
        logic [4:0]  q_a2;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic [31:0] e_pc;
        logic        e_rdy;
        logic        e_h1;
        logic        e_h2;
        logic        e_stall;
        logic [2:0]  e_cnt;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_p(input logic we, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        p_we = we; p_a3 = a3; p_wd = wd; p_pc = pc;
    endtask

    task automatic drive_m(input logic v, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        m_valid = v; m_a3 = a3; m_wd = wd; m_pc = pc;
    endtask

    function automatic vec_t mk(
        input logic pwe, input logic [4:0] pa3, input logic [31:0] pwd, input logic [31:0] ppc,
        input logic mv, input logic [4:0] ma3, input logic [31:0] mwd, input logic [31:0] mpc,
        input logic [4:0] qa1, input logic [4:0] qa2,
        input logic [4:0] ea3, input logic [31:0] ewd, input logic [31:0] epc,
        input logic erdy, input logic eh1, input logic eh2, input logic est, input logic [2:0] ecnt);
        vec_t v;
        v.p_we = pwe; v.p_a3 = pa3; v.p_wd = pwd; v.p_pc = ppc;
        v.m_valid = mv; v.m_a3 = ma3; v.m_wd = mwd; v.m_pc = mpc;
        v.q_a1 = qa1; v.q_a2 = qa2;
        v.e_a3 = ea3; v.e_wd = ewd; v.e_pc = epc;
        v.e_rdy = erdy; v.e_h1 = eh1; v.e_h2 = eh2; v.e_stall = est; v.e_cnt = ecnt;
        return v;
    endfunction

    initial begin
        // Each row is one cycle; expectations are for the cycle before its posedge
        //            pwe pa3 pwd      ppc     mv ma3 mwd           mpc     qa1 qa2  ea3 ewd           epc     rdy h1 h2 st cnt
        vecs[0]  = mk(0, 0,  32'h0,    32'h0,   0, 0,  32'h0,        32'h0,   0,  0,   0,  32'h0,        32'h0,   1, 0, 0, 0, 0);
        vecs[1]  = mk(1, 5,  32'h1234, 32'h100, 0, 0,  32'h0,        32'h0,   0,  0,   5,  32'h1234,     32'h100, 1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0,  32'h55,   32'h104, 0, 0,  32'h0,        32'h0,   0,  0,   0,  32'h0,        32'h0,   1, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0,  32'h0,    32'h0,   1, 8,  32'hDEADBEEF, 32'h200, 8,  0,   0,  32'h0,        32'h0,   1, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0,  32'h0,    32'h0,   0, 0,  32'h0,        32'h0,   8,  0,   8,  32'hDEADBEEF, 32'h200, 1, 1, 0, 0, 1);
        vecs[5]  = mk(0, 0,  32'h0,    32'h0,   0, 0,  32'h0,        32'h0,   8,  0,   0,  32'h0,        32'h0,   1, 0, 0, 0, 0);
        vecs[6]  = mk(1, 3,  32'h33,   32'h108, 1, 12, 32'hC0C0,     32'h300, 0,  0,   3,  32'h33,       32'h108, 1, 0, 0, 0, 0);
        vecs[7]  = mk(1, 4,  32'h44,   32'h10C, 0, 0,  32'h0,        32'h0,   12, 0,   4,  32'h44,       32'h10C, 1, 1, 0, 0, 1);
        vecs[8]  = mk(1, 4,  32'h45,   32'h110, 1, 0,  32'h99,       32'h304, 0,  12,  4,  32'h45,       32'h110, 1, 0, 1, 0, 1);
        vecs[9]  = mk(0, 0,  32'h0,    32'h0,   0, 0,  32'h0,        32'h0,   12, 12,  12, 32'hC0C0,     32'h300, 1, 1, 1, 0, 1);
        vecs[10] = mk(0, 0,  32'h0,    32'h0,   0, 0,  32'h0,        32'h0,   12, 0,   0,  32'h0,        32'h0,   1, 0, 0, 0, 0);

        reset = 1'b1;
        drive_p(1'b0, 5'd0, 32'd0, 32'd0);
        drive_m(1'b0, 5'd0, 32'd0, 32'd0);
        q_a1 = 5'd0; q_a2 = 5'd0;

        // Reset cycle
        @(negedge clk);
        chk("rst.m_ready", 32'(m_ready), 32'd0);
        chk("rst.grf_a3", 32'(grf_a3), 32'd0);
        next_cycle();
        reset = 1'b0;

        // Vector table
        for (int i = 0; i < NV; i++) begin
            drive_p(vecs[i].p_we, vecs[i].p_a3, vecs[i].p_wd, vecs[i].p_pc);
            drive_m(vecs[i].m_valid, vecs[i].m_a3, vecs[i].m_wd, vecs[i].m_pc);
            q_a1 = vecs[i].q_a1; q_a2 = vecs[i].q_a2;
            @(negedge clk);
            chk($sformatf("v%0d.grf_a3", i), 32'(grf_a3), 32'(vecs[i].e_a3));
            chk($sformatf("v%0d.grf_wd", i), grf_wd, vecs[i].e_wd);
            chk($sformatf("v%0d.grf_pc", i), grf_pc, vecs[i].e_pc);
            chk($sformatf("v%0d.m_ready", i), 32'(m_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d.q_hit1", i), 32'(q_hit1), 32'(vecs[i].e_h1));
            chk($sformatf("v%0d.q_hit2", i), 32'(q_hit2), 32'(vecs[i].e_h2));
            chk($sformatf("v%0d.stall", i), 32'(stall_req), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d.cnt", i), 32'(fifo_cnt), 32'(vecs[i].e_cnt));
            next_cycle();
        end
        drive_m(1'b0, 5'd0, 32'd0, 32'd0);
        q_a1 = 5'd0; q_a2 = 5'd0;

        // Fill to full while the pipeline holds the port
        for (int k = 0; k < 4; k++) begin
            drive_p(1'b1, 5'd7, 32'h77, 32'h500);
            drive_m(1'b1, 5'(16 + k), 32'h1000 + 32'(k), 32'h400 + 32'(4 * k));
            @(negedge clk);
            chk($sformatf("fill%0d.m_ready", k), 32'(m_ready), 32'd1);
            chk($sformatf("fill%0d.grf_a3", k), 32'(grf_a3), 32'd7);
            chk($sformatf("fill%0d.cnt", k), 32'(fifo_cnt), 32'(k));
            next_cycle();
        end
        drive_m(1'b1, 5'd31, 32'hBAD, 32'hBAD);
        @(negedge clk);
        chk("full.m_ready", 32'(m_ready), 32'd0);
        chk("full.cnt", 32'(fifo_cnt), 32'd4);
        next_cycle();
        drive_p(1'b0, 5'd0, 32'd0, 32'd0);
        drive_m(1'b0, 5'd0, 32'd0, 32'd0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("drain%0d.grf_a3", j), 32'(grf_a3), 32'(16 + j));
            chk($sformatf("drain%0d.grf_wd", j), grf_wd, 32'h1000 + 32'(j));
            chk($sformatf("drain%0d.grf_pc", j), grf_pc, 32'h400 + 32'(4 * j));
            chk($sformatf("drain%0d.cnt", j), 32'(fifo_cnt), 32'(4 - j));
            if (j == 0) chk("drain0.m_ready", 32'(m_ready), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("drained.cnt", 32'(fifo_cnt), 32'd0);
        chk("drained.grf_a3", 32'(grf_a3), 32'd0);
        chk("drained.m_ready", 32'(m_ready), 32'd1);
        next_cycle();

        // Starvation: one entry blocked by continuous pipeline writes
        drive_m(1'b1, 5'd9, 32'h99, 32'h600);
        @(negedge clk);
        chk("starve.push.cnt", 32'(fifo_cnt), 32'd0);
        next_cycle();
        drive_m(1'b0, 5'd0, 32'd0, 32'd0);
        drive_p(1'b1, 5'd2, 32'h22, 32'h700);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            chk($sformatf("starve%0d.stall", c), 32'(stall_req), (c >= 9) ? 32'd1 : 32'd0);
            chk($sformatf("starve%0d.grf_a3", c), 32'(grf_a3), 32'd2);
            chk($sformatf("starve%0d.cnt", c), 32'(fifo_cnt), 32'd1);
            next_cycle();
        end
        drive_p(1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("starve.rel.stall", 32'(stall_req), 32'd1);
        chk("starve.rel.grf_a3", 32'(grf_a3), 32'd9);
        chk("starve.rel.grf_wd", grf_wd, 32'h99);
        next_cycle();
        @(negedge clk);
        chk("starve.after.stall", 32'(stall_req), 32'd0);
        chk("starve.after.cnt", 32'(fifo_cnt), 32'd0);
        next_cycle();

        // Reset with three entries queued
        drive_p(1'b1, 5'd2, 32'h22, 32'h704);
        for (int k = 0; k < 3; k++) begin
            drive_m(1'b1, 5'(20 + k), 32'h2000 + 32'(k), 32'h800 + 32'(4 * k));
            next_cycle();
        end
        drive_m(1'b0, 5'd0, 32'd0, 32'd0);
        q_a1 = 5'd21; q_a2 = 5'd22;
        @(negedge clk);
        chk("prerst.cnt", 32'(fifo_cnt), 32'd3);
        chk("prerst.q_hit1", 32'(q_hit1), 32'd1);
        chk("prerst.q_hit2", 32'(q_hit2), 32'd1);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("midrst.grf_a3", 32'(grf_a3), 32'd0);
        chk("midrst.m_ready", 32'(m_ready), 32'd0);
        next_cycle();
        reset = 1'b0;
        drive_p(1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("postrst.cnt", 32'(fifo_cnt), 32'd0);
        chk("postrst.grf_a3", 32'(grf_a3), 32'd0);
        chk("postrst.q_hit1", 32'(q_hit1), 32'd0);
        chk("postrst.q_hit2", 32'(q_hit2), 32'd0);
        chk("postrst.stall", 32'(stall_req), 32'd0);
        chk("postrst.m_ready", 32'(m_ready), 32'd1);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
